// File: rtl/mpp_pkg.sv
// Shared constants, address type and sequencer state encoding for the mpp instruction path.
package mpp_pkg;

    localparam int          ADDR_W      = 6;
    localparam int          DEPTH       = 64;
    localparam logic [7:0]  NOP_OP_DEF  = 8'h00;
    localparam logic [7:0]  HALT_OP_DEF = 8'h7F;
    localparam logic [1:0]  JMP_PFX     = 2'b11;
    localparam logic [1:0]  JNZ_PFX     = 2'b10;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_e;

endpackage

// File: rtl/mpp_sequencer_if.sv
// Host/core-facing signals of the sequencer; master is the host side, slave the sequencer.
interface mpp_sequencer_if;
    import mpp_pkg::*;

    logic        prog_we;
    addr_t       prog_addr;
    logic [7:0]  prog_data;
    logic        start;
    logic        cond;
    logic [7:0]  instruction;
    addr_t       pc;
    logic        running;
    logic        halted;

    modport master (
        output prog_we, prog_addr, prog_data, start, cond,
        input  instruction, pc, running, halted
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, cond,
        output instruction, pc, running, halted
    );

endinterface

// File: rtl/mpp_prog_mem.sv
// 64x8 program RAM, one write port and one registered read port (1-cycle latency).
// A write to the address being read in the same cycle returns the new data.
module mpp_prog_mem
    import mpp_pkg::*;
(
    input  logic        clk,
    input  logic        we_i,
    input  addr_t       waddr_i,
    input  logic [7:0]  wdata_i,
    input  addr_t       raddr_i,
    output logic [7:0]  rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mpp_sequencer.sv
// Issues one program word per clock to mpp, executing JMP/JNZ/HALT locally as NOPs.
// First word appears two edges after start; branches cost only their own NOP slot.
module mpp_sequencer
    import mpp_pkg::*;
#(
    parameter logic [7:0] NOP_OP  = NOP_OP_DEF,
    parameter logic [7:0] HALT_OP = HALT_OP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mpp_sequencer_if.slave   seq
);

    state_e      state_q, state_d;
    addr_t       pc_q, pc_d;
    logic [7:0]  instr_q, instr_d;
    logic [7:0]  word;
    logic        mem_we;
    addr_t       pc_inc;
    addr_t       target;

    // Read address is the next PC so the word for the next cycle is ready without a bubble.
    mpp_prog_mem u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (seq.prog_addr),
        .wdata_i (seq.prog_data),
        .raddr_i (pc_d),
        .rdata_o (word)
    );

    assign pc_inc = pc_q + addr_t'(1);
    assign target = word[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = NOP_OP;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                mem_we = seq.prog_we;
                if (seq.start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (word == HALT_OP) begin
                    state_d = ST_HALTED;
                end else if (word[7:6] == JMP_PFX) begin
                    pc_d = target;
                end else if (word[7:6] == JNZ_PFX) begin
                    pc_d = seq.cond ? target : pc_inc;
                end else begin
                    instr_d = word;
                    pc_d    = pc_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= NOP_OP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign seq.instruction = instr_q;
    assign seq.pc          = pc_q;
    assign seq.running     = (state_q == ST_RUN);
    assign seq.halted      = (state_q == ST_HALTED);

endmodule
